// File: rtl/c_joiner2_pkg.sv
// Shared types and constants for the two-input drive/free joiner.
package c_joiner2_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FIRE    = 1'b1
    } state_e;

    localparam int unsigned ERR_OVF0   = 0;
    localparam int unsigned ERR_OVF1   = 1;
    localparam int unsigned ERR_CREDIT = 2;
    localparam int unsigned ERR_W      = 3;
    localparam int unsigned WDOG_W     = 16;
    localparam int unsigned PCNT_W     = 4;

endpackage

// File: rtl/c_joiner2_if.sv
// Handshake bundle between two upstreams, the joiner and one downstream.
// o_wdog exists only when JOIN2_WATCHDOG_EN is defined.
interface c_joiner2_if #(
    parameter int unsigned DATA_WIDTHI0 = 12,
    parameter int unsigned DATA_WIDTHI1 = 20
);
    import c_joiner2_pkg::*;

    localparam int unsigned DATA_WIDTHOUT = DATA_WIDTHI0 + DATA_WIDTHI1;

    logic                     i_drive0;
    logic [DATA_WIDTHI0-1:0]  i_data0;
    logic                     i_drive1;
    logic [DATA_WIDTHI1-1:0]  i_data1;
    logic                     i_freeNext;
    logic                     o_free0;
    logic                     o_free1;
    logic                     o_driveNext;
    logic [DATA_WIDTHOUT-1:0] o_data;
    logic [ERR_W-1:0]         o_err;
`ifdef JOIN2_WATCHDOG_EN
    logic                     o_wdog;
`endif

    // Joiner side
    modport slave (
        input  i_drive0, i_data0, i_drive1, i_data1, i_freeNext,
        output o_free0, o_free1, o_driveNext, o_data, o_err
`ifdef JOIN2_WATCHDOG_EN
        , output o_wdog
`endif
    );

    // Environment side (upstreams + downstream)
    modport master (
        output i_drive0, i_data0, i_drive1, i_data1, i_freeNext,
        input  o_free0, o_free1, o_driveNext, o_data, o_err
`ifdef JOIN2_WATCHDOG_EN
        , input o_wdog
`endif
    );

endinterface

// File: rtl/c_joiner2_sync_edge_tap.sv
// Rising-level event detector; previous level resets high so a level held
// through reset release does not produce an event.
module sync_edge_tap (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_c_o
);

    logic prev_q;

    // Track the previous sampled level
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_c_o = level_i & ~prev_q;

endmodule

// File: rtl/c_joiner2_sync.sv
// Two-input joiner: collects one payload per upstream, fires one joined
// drive pulse downstream and frees both upstreams.
// Optional watchdog: define JOIN2_WATCHDOG_EN.
module c_joiner2_sync
    import c_joiner2_pkg::*;
#(
    parameter  int unsigned DATA_WIDTHI0  = 12,
    parameter  int unsigned DATA_WIDTHI1  = 20,
    parameter  int unsigned PULSE_W       = 2,
    parameter  int unsigned INIT_FREE     = 1,
    localparam int unsigned DATA_WIDTHOUT = DATA_WIDTHI0 + DATA_WIDTHI1
) (
    input  logic        clk,
    input  logic        rst,
    c_joiner2_if.slave  bus
);

    logic ev_drive0_c;
    logic ev_drive1_c;
    logic ev_free_c;
    logic fire_c;

    state_e                   state_q;
    logic [PCNT_W-1:0]        pcnt_q;
    logic                     pulse_q;
    logic [DATA_WIDTHOUT-1:0] data_q;
    logic [DATA_WIDTHI0-1:0]  slot0_q;
    logic [DATA_WIDTHI1-1:0]  slot1_q;
    logic                     full0_q;
    logic                     full1_q;
    logic                     credit_q;
    logic [ERR_W-1:0]         err_q;

    sync_edge_tap u_tap_drive0 (.clk(clk), .rst(rst), .level_i(bus.i_drive0),   .rise_c_o(ev_drive0_c));
    sync_edge_tap u_tap_drive1 (.clk(clk), .rst(rst), .level_i(bus.i_drive1),   .rise_c_o(ev_drive1_c));
    sync_edge_tap u_tap_free   (.clk(clk), .rst(rst), .level_i(bus.i_freeNext), .rise_c_o(ev_free_c));

    // A fresh freeNext event counts as credit at the same edge
    assign fire_c = (state_q == COLLECT) & full0_q & full1_q & (credit_q | ev_free_c);

    // Pulse FSM: one join per fire, pulses held PULSE_W cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            pcnt_q  <= '0;
            pulse_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (fire_c) begin
                        state_q <= FIRE;
                        pulse_q <= 1'b1;
                        pcnt_q  <= PCNT_W'(PULSE_W - 1);
                        data_q  <= {slot1_q, slot0_q};
                    end
                end
                FIRE: begin
                    if (pcnt_q == '0) begin
                        state_q <= COLLECT;
                        pulse_q <= 1'b0;
                    end else begin
                        pcnt_q <= pcnt_q - PCNT_W'(1);
                    end
                end
                default: begin
                    state_q <= COLLECT;
                    pulse_q <= 1'b0;
                end
            endcase
        end
    end

    // Payload slots: capture only into an empty slot, clear on fire
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            full0_q <= 1'b0;
            full1_q <= 1'b0;
        end else if (fire_c) begin
            full0_q <= 1'b0;
            full1_q <= 1'b0;
        end else begin
            if (ev_drive0_c && !full0_q) begin
                slot0_q <= bus.i_data0;
                full0_q <= 1'b1;
            end
            if (ev_drive1_c && !full1_q) begin
                slot1_q <= bus.i_data1;
                full1_q <= 1'b1;
            end
        end
    end

    // Downstream credit: set by freeNext, consumed by fire
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= (INIT_FREE != 0);
        end else if (fire_c) begin
            credit_q <= 1'b0;
        end else if (ev_free_c) begin
            credit_q <= 1'b1;
        end
    end

    // Sticky protocol errors; a full slot is also full on its fire edge
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            if (ev_drive0_c && full0_q) err_q[ERR_OVF0]   <= 1'b1;
            if (ev_drive1_c && full1_q) err_q[ERR_OVF1]   <= 1'b1;
            if (ev_free_c && credit_q)  err_q[ERR_CREDIT] <= 1'b1;
        end
    end

    assign bus.o_driveNext = pulse_q;
    assign bus.o_free0     = pulse_q;
    assign bus.o_free1     = pulse_q;
    assign bus.o_data      = data_q;
    assign bus.o_err       = err_q;

`ifdef JOIN2_WATCHDOG_EN
    logic [WDOG_W-1:0] wcnt_q;
    logic [WDOG_W-1:0] wcnt_d;
    logic              wdog_q;

    // Count cycles spent with both slots full but no downstream credit
    always_comb begin
        wcnt_d = wcnt_q;
        if (fire_c) begin
            wcnt_d = '0;
        end else if (full0_q && full1_q && !credit_q && (wcnt_q != '1)) begin
            wcnt_d = wcnt_q + WDOG_W'(1);
        end
    end

    // Watchdog counter and sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            if (wcnt_d == '1) wdog_q <= 1'b1;
        end
    end

    assign bus.o_wdog = wdog_q;
`endif

endmodule
